seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- All digits share one combinational BCD-to-seven-segment decoder:
  - This block drives the decoder's 4-bit input (`bcd_out`) and the active-low digit enables (`an_out`).
  - The decoder's 7-bit output goes straight to the segment pins.
- Provides:
  - a double-buffered digit register with frame-boundary update;
  - leading-zero blanking;
  - dead time between digits to suppress ghosting.

Parameters:
- `NUM_DIGITS`, 4, number of digits scanned; digit 0 is least significant.
- `PRESCALE`, 50000, clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 16, cycles at the start of each slot with all anodes off; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  1  scan enable.
- `load`  in  1  single-cycle strobe; captures `digits_in` into the staging register.
- `digits_in`  in  4*`NUM_DIGITS`  packed BCD digits; `[3:0]` = digit 0.
- `lz_blank`  in  1  1 = blank leading zeros.
- `bcd_out`  out  4  to shared decoder; 4'hF = blank (decoder outputs all segments off).
- `an_out`  out  `NUM_DIGITS`  digit enables, active-low, one-cold while showing.
- `load_ack`  out  1  one-cycle pulse when staged data becomes active.
- `frame_done`  out  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Reset (`rst_n`=0 at a clock edge) sets:
  - state IDLE, `an_out` all 1s, `bcd_out` 4'hF;
  - `load_ack`=0, `frame_done`=0;
  - digit index 0, slot counter 0;
  - staging and active registers all 1s (every digit blank), pending flag 0.
- Reset mid-scan takes effect on that edge; there is no completion of the current slot.
- All outputs are registered. `an_out` and `bcd_out` change on the same edge.
- States are IDLE, BLANK and SHOW.
- IDLE:
  - `an_out` all 1s, `bcd_out` F, index 0, counter 0.
  - If `en`=1, go to BLANK on the next edge.
- BLANK:
  - `an_out` all 1s, `bcd_out` F.
  - Lasts `BLANK_CYCLES` cycles, then go to SHOW.
- SHOW:
  - `an_out[idx]`=0, other anodes 1; `bcd_out` = effective digit `idx`.
  - Lasts `PRESCALE`−`BLANK_CYCLES` cycles.
  - At the end of the slot, `idx` increments and the state returns to BLANK.
  - Wrap from `NUM_DIGITS`−1 to 0: `frame_done` pulses on the final SHOW cycle.
- A slot is exactly `PRESCALE` cycles; a frame is exactly `NUM_DIGITS`*`PRESCALE` cycles.
- `en`=0 in any state: go to IDLE on the next edge (all off). Re-enable starts at digit 0.
- Staging and update:
  - `load`=1 writes `digits_in` to staging and sets pending. `load` is accepted in any state, including IDLE.
  - Transfer staging→active happens on the frame-done edge if pending is set. On that edge `load_ack` pulses and pending clears.
  - When `load` and the transfer edge coincide, the transfer uses the previous staging value, the new value is stored in staging, and pending stays 1. The new value transfers at the next frame.
  - Back-to-back `load`s: the last one wins.
  - While in IDLE with pending set, transfer happens immediately on the next edge, with a `load_ack` pulse.
- Effective digit:
  - `lz_blank`=1: digit k (k ≥ 1) outputs 4'hF if it and all digits above it are 0. Digit 0 is never blanked (value 0 displays "0").
  - `lz_blank`=0: raw value.
  - Values A–E pass through unchanged; the decoder blanks them.
  - `lz_blank` is sampled combinationally against the active register at each SHOW.

Test Plan (`NUM_DIGITS`=4, `PRESCALE`=8, `BLANK_CYCLES`=2):
- Reset then `en`=1, no load → all slots show `bcd_out`=F. `an_out` sequence 1110, 1101, 1011, 0111, each asserted 6 cycles after 2 all-off cycles. `frame_done` every 32 cycles. No `load_ack`.
- `load` `digits_in`=16'h1234 while scanning → `load_ack` at the next frame end. The following frame shows digit0=4, digit1=3, digit2=2, digit3=1 in slot order.
- Active 16'h0045 with `lz_blank`=1 → digits 3 and 2 show F, digit1=4, digit0=5. Active 16'h0000 → only digit 0 shows 0. With `lz_blank`=0 → all four digits show 0.
- `load`=16'h5678 on the frame-done cycle (prior staging 16'h1111, pending) → active becomes 1111 with `load_ack`. 5678 becomes active one frame later with a second `load_ack`.
- `en` dropped during SHOW of digit 2 → next edge `an_out`=1111, `bcd_out`=F. Re-raising `en` restarts at BLANK for digit 0.
- `rst_n`=0 for one cycle mid-SHOW with active 16'h9876 → outputs return to reset values on that edge and active reads all 1s. After `en`, all digits blank.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit (parameterizable) multiplexed seven-segment scan controller.
// Drives a shared BCD decoder and active-low anodes with inter-digit dead time.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    load_ack,
  output logic                    frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DW-1:0]         stage_q, active_q, eff;
  logic                  pending, xfer, zero_above, fd_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [3:0]            bcd_nxt;

  // Walk down from the top digit; a digit is blanked only while everything above it is zero.
  always_comb begin
    eff        = active_q;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (active_q[4*k +: 4] == 4'd0);
      if (lz_blank && zero_above) eff[4*k +: 4] = 4'hF;
    end
  end

  // cnt runs across the whole slot: BLANK covers the first BLANK_CYCLES counts, SHOW the rest.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        BLANK: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(BLANK_CYCLES - 1)) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == CW'(PRESCALE - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    an_nxt  = '1;
    bcd_nxt = 4'hF;
    if (state_nxt == SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      bcd_nxt         = eff[4*int'(idx_nxt) +: 4];
    end
    fd_nxt = (state_nxt == SHOW) && (idx_nxt == IW'(NUM_DIGITS - 1)) &&
             (cnt_nxt == CW'(PRESCALE - 1));
  end

  // frame_done is high during the final SHOW cycle, so its closing edge is the swap edge.
  assign xfer = pending && (frame_done || state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      an_out     <= '1;
      bcd_out    <= 4'hF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      stage_q    <= '1;
      active_q   <= '1;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      an_out     <= an_nxt;
      bcd_out    <= bcd_nxt;
      frame_done <= fd_nxt;
      load_ack   <= xfer;
      if (xfer) active_q <= stage_q;
      if (load) begin
        stage_q <= digits_in;
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end
endmodule
